rob_commit: RTL

//  In-order retirement stage directly downstream of the reorder buffer (ROB).
//  - Each cycle, retires up to RET_COUNT completed entries from the ROB head.
//  - Drives the ROB consume handshake and registered register-file write ports.
//  - Sequences branch-mispredict recovery: retires branch + delay slot, then issues flush/redirect.

---
 rtl/rob_commit_if.sv | 42 ++++
 rtl/rob_commit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rob_commit_if.sv
// ROB-to-retirement bundle: the ROB head window going in, plus the consume handshake,
// register-file write ports, flush/redirect strobes and retire counter coming back out.
interface rob_commit_if #(
    parameter int RET_COUNT  = 4,
    parameter int DEPTH      = 16,
    parameter int DEPTHLOG2  = $clog2(DEPTH),
    parameter int RETCNTLOG2 = $clog2(RET_COUNT)
);
    logic [DEPTHLOG2-1:0]        head_idx;
    logic [DEPTHLOG2:0]          used_count;
    logic [RET_COUNT-1:0]        slot_valid;
    logic [RET_COUNT-1:0][4:0]   slot_dest_reg;
    logic [RET_COUNT-1:0]        slot_dest_valid;
    logic [RET_COUNT-1:0][31:0]  slot_result;
    logic [RET_COUNT-1:0]        slot_mispredict;
    logic [RET_COUNT-1:0][31:0]  slot_target;

    logic                        consume;
    logic [RETCNTLOG2-1:0]       consume_count;
    logic [RET_COUNT-1:0]        rf_wr_en;
    logic [RET_COUNT-1:0][4:0]   rf_wr_addr;
    logic [RET_COUNT-1:0][31:0]  rf_wr_data;
    logic                        flush;
    logic [DEPTHLOG2-1:0]        flush_idx;
    logic                        redirect_valid;
    logic [31:0]                 redirect_pc;
    logic [31:0]                 retired_count;

    modport master (
        output head_idx, used_count, slot_valid, slot_dest_reg, slot_dest_valid,
               slot_result, slot_mispredict, slot_target,
        input  consume, consume_count, rf_wr_en, rf_wr_addr, rf_wr_data,
               flush, flush_idx, redirect_valid, redirect_pc, retired_count
    );

    modport slave (
        input  head_idx, used_count, slot_valid, slot_dest_reg, slot_dest_valid,
               slot_result, slot_mispredict, slot_target,
        output consume, consume_count, rf_wr_en, rf_wr_addr, rf_wr_data,
               flush, flush_idx, redirect_valid, redirect_pc, retired_count
    );
endinterface

// File: rtl/rob_commit.sv
// In-order retirement stage: retires up to RET_COUNT completed ROB head entries per cycle,
// drives registered RF writes, and sequences branch + delay-slot retirement before a flush.
module rob_commit #(
    parameter int RET_COUNT  = 4,
    parameter int DEPTH      = 16,
    parameter int DEPTHLOG2  = $clog2(DEPTH),
    parameter int RETCNTLOG2 = $clog2(RET_COUNT)
) (
    input  logic        clock,
    input  logic        reset_n,
    rob_commit_if.slave rob
);
    localparam int CNTW = RETCNTLOG2 + 1;
    localparam int UCW  = DEPTHLOG2 + 1;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_WAIT_BDS = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]                 state;
    logic [1:0]                 state_next;
    logic [CNTW-1:0]            win_n;
    logic [CNTW-1:0]            retire_n;
    logic                       run;
    logic                       mp_found;
    logic [CNTW-1:0]            mp_slot;
    logic [31:0]                mp_target;
    logic [UCW-1:0]             idx_sum;
    logic [DEPTHLOG2-1:0]       mp_idx;
    logic                       consume_int;
    logic [RET_COUNT-1:0]       wr_en_next;

    logic [DEPTHLOG2-1:0]       latched_idx;
    logic [31:0]                latched_pc;
    logic [RET_COUNT-1:0]       rf_wr_en_q;
    logic [RET_COUNT-1:0][4:0]  rf_wr_addr_q;
    logic [RET_COUNT-1:0][31:0] rf_wr_data_q;
    logic                       flush_q;
    logic [DEPTHLOG2-1:0]       flush_idx_q;
    logic [31:0]                redirect_pc_q;
    logic [31:0]                retired_count_q;

    // Eligible window: leading run of completed slots, never reaching past the ROB occupancy.
    always_comb begin
        win_n = '0;
        run   = 1'b1;
        for (int i = 0; i < RET_COUNT; i++) begin
            if (run && rob.slot_valid[i] && (UCW'(i) < rob.used_count)) begin
                win_n = CNTW'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        mp_found  = 1'b0;
        mp_slot   = '0;
        mp_target = '0;
        for (int i = 0; i < RET_COUNT; i++) begin
            if (!mp_found && (CNTW'(i) < win_n) && rob.slot_mispredict[i]) begin
                mp_found  = 1'b1;
                mp_slot   = CNTW'(i);
                mp_target = rob.slot_target[i];
            end
        end
        idx_sum = {1'b0, rob.head_idx} + UCW'(mp_slot);
        if (idx_sum >= UCW'(DEPTH)) begin
            mp_idx = DEPTHLOG2'(idx_sum - UCW'(DEPTH));
        end else begin
            mp_idx = DEPTHLOG2'(idx_sum);
        end
    end

    // A mispredicted branch always takes its delay slot with it; if the slot is not
    // yet available the branch retires alone and the delay slot is collected later.
    always_comb begin
        retire_n   = '0;
        state_next = state;
        case (state)
            ST_RUN: begin
                if (mp_found) begin
                    if ((mp_slot + CNTW'(1)) < win_n) begin
                        retire_n   = mp_slot + CNTW'(2);
                        state_next = ST_REDIRECT;
                    end else begin
                        retire_n   = mp_slot + CNTW'(1);
                        state_next = ST_WAIT_BDS;
                    end
                end else begin
                    retire_n = win_n;
                end
            end
            ST_WAIT_BDS: begin
                if (rob.slot_valid[0] && (rob.used_count != '0)) begin
                    retire_n   = CNTW'(1);
                    state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign consume_int       = reset_n && (retire_n != '0);
    assign rob.consume       = consume_int;
    assign rob.consume_count = RETCNTLOG2'(retire_n - CNTW'(1));

    // Within one retire group the youngest writer of a register wins; r0 is never written.
    always_comb begin
        wr_en_next = '0;
        for (int i = 0; i < RET_COUNT; i++) begin
            if ((CNTW'(i) < retire_n) && rob.slot_dest_valid[i] && (rob.slot_dest_reg[i] != 5'd0)) begin
                wr_en_next[i] = 1'b1;
                for (int j = i + 1; j < RET_COUNT; j++) begin
                    if ((CNTW'(j) < retire_n) && rob.slot_dest_valid[j] &&
                        (rob.slot_dest_reg[j] == rob.slot_dest_reg[i])) begin
                        wr_en_next[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_RUN;
            latched_idx     <= '0;
            latched_pc      <= '0;
            rf_wr_en_q      <= '0;
            rf_wr_addr_q    <= '0;
            rf_wr_data_q    <= '0;
            flush_q         <= 1'b0;
            flush_idx_q     <= '0;
            redirect_pc_q   <= '0;
            retired_count_q <= '0;
        end else begin
            state        <= state_next;
            rf_wr_en_q   <= wr_en_next;
            rf_wr_addr_q <= rob.slot_dest_reg;
            rf_wr_data_q <= rob.slot_result;
            if (consume_int) begin
                retired_count_q <= retired_count_q + 32'(retire_n);
            end
            if ((state == ST_RUN) && mp_found) begin
                latched_idx <= mp_idx;
                latched_pc  <= mp_target;
            end
            flush_q <= (state_next == ST_REDIRECT);
            if ((state == ST_RUN) && (state_next == ST_REDIRECT)) begin
                flush_idx_q   <= mp_idx;
                redirect_pc_q <= mp_target;
            end else if ((state == ST_WAIT_BDS) && (state_next == ST_REDIRECT)) begin
                flush_idx_q   <= latched_idx;
                redirect_pc_q <= latched_pc;
            end
        end
    end

    assign rob.rf_wr_en       = rf_wr_en_q;
    assign rob.rf_wr_addr     = rf_wr_addr_q;
    assign rob.rf_wr_data     = rf_wr_data_q;
    assign rob.flush          = flush_q;
    assign rob.redirect_valid = flush_q;
    assign rob.flush_idx      = flush_idx_q;
    assign rob.redirect_pc    = redirect_pc_q;
    assign rob.retired_count  = retired_count_q;
endmodule
